// File: rtl/sync_fifo_pkg.sv
// Shared constants and read-mode type for the thresholded synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEFAULT_DEPTH      = 256;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic {
    MODE_REG  = 1'b0,
    MODE_FWFT = 1'b1
  } read_mode_e;

  function automatic read_mode_e mode_from_param(input int fwft);
    return (fwft != 0) ? MODE_FWFT : MODE_REG;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, one clock.
// Same-address read/write returns the old word; callers bypass where needed.
module fifo_ram #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_thresh.sv
// Synchronous FIFO with registered occupancy flags, programmable almost-full/empty
// thresholds, sticky overflow/underflow and selectable registered or FWFT read.
module sync_fifo_thresh
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PTR_WIDTH  = $clog2(DEPTH),
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [PTR_WIDTH:0]    af_thresh,
  input  logic [PTR_WIDTH:0]    ae_thresh,
  output logic                  full,
  output logic                  empty,
  output logic                  half_full,
  output logic                  half_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam read_mode_e           MODE     = mode_from_param(FWFT);
  localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   CNT_HALF = (PTR_WIDTH+1)'(DEPTH / 2);
  localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0] waddr_q, waddr_d;
  logic [PTR_WIDTH-1:0] raddr_q, raddr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 full_q, empty_q, half_full_q, half_empty_q;
  logic                 almost_full_q, almost_empty_q;
  logic                 wr_accept, rd_accept;
  logic                 ram_rd_en;
  logic [PTR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Registered flags make full/empty arbitration on simultaneous requests implicit.
  assign wr_accept = w_en && !full_q && !rst;
  assign rd_accept = r_en && !empty_q && !rst;

  always_comb begin
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (wr_accept) begin
      waddr_d = waddr_q + PTR_ONE;
    end
    if (rd_accept) begin
      raddr_d = raddr_q + PTR_ONE;
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (w_en && full_q) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end
    if (r_en && empty_q) begin
      udf_d = 1'b1;
    end else if (clr_err) begin
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q        <= '0;
      raddr_q        <= '0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      udf_q          <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      half_full_q    <= 1'b0;
      half_empty_q   <= 1'b1;
      almost_full_q  <= (af_thresh == '0);
      almost_empty_q <= 1'b1;
    end else begin
      waddr_q        <= waddr_d;
      raddr_q        <= raddr_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      udf_q          <= udf_d;
      full_q         <= (count_d == CNT_FULL);
      empty_q        <= (count_d == '0);
      half_full_q    <= (count_d >= CNT_HALF);
      half_empty_q   <= (count_d < CNT_HALF);
      almost_full_q  <= (count_d >= af_thresh);
      almost_empty_q <= (count_d <= ae_thresh);
    end
  end

  fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (waddr_q),
    .wr_data (data_in),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  generate
    if (MODE == MODE_FWFT) begin : g_fwft
      logic                  bypass_q;
      logic [DATA_WIDTH-1:0] wdata_q;

      // Prefetch the head for the next cycle; a write landing on that very
      // address this edge is not yet visible in the RAM, so forward it.
      assign ram_rd_en   = 1'b1;
      assign ram_rd_addr = raddr_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          bypass_q <= 1'b0;
          wdata_q  <= '0;
        end else begin
          bypass_q <= wr_accept && (waddr_q == raddr_d);
          wdata_q  <= data_in;
        end
      end

      assign data_out = bypass_q ? wdata_q : ram_rd_data;
    end else begin : g_reg
      assign ram_rd_en   = rd_accept;
      assign ram_rd_addr = raddr_q;
      assign data_out    = ram_rd_data;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign half_full    = half_full_q;
  assign half_empty   = half_empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed plus random traffic into registered-read and FWFT instances, checked
// against a queue-based reference model of the FIFO rules.
module tb_sync_fifo_thresh;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int PW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [PW:0]   af_thresh = 5'd12;
  logic [PW:0]   ae_thresh = 5'd3;

  logic [DW-1:0] r_dout, f_dout;
  logic [PW:0]   r_count, f_count;
  logic r_full, r_empty, r_hf, r_he, r_af, r_ae, r_ovf, r_udf;
  logic f_full, f_empty, f_hf, f_he, f_af, f_ae, f_ovf, f_udf;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic [DW-1:0] m_dout = '0;

  always #5 clk = ~clk;

  sync_fifo_thresh #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(r_dout), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .full(r_full), .empty(r_empty), .half_full(r_hf), .half_empty(r_he),
    .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
    .overflow(r_ovf), .underflow(r_udf), .clr_err(clr_err)
  );

  sync_fifo_thresh #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(f_dout), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .full(f_full), .empty(f_empty), .half_full(f_hf), .half_empty(f_he),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input bit s_rst, input bit w, input bit r, input bit clr, input logic [DW-1:0] d);
    int n;
    bit wr_ok, rd_ok;
    logic [7:0] exp_flags;
    rst = s_rst; w_en = w; r_en = r; clr_err = clr; data_in = d;
    @(posedge clk);
    step_no++;
    if (s_rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
    end else begin
      n     = mq.size();
      wr_ok = w && (n < DEPTH);
      rd_ok = r && (n > 0);
      if (rd_ok) m_dout = mq.pop_front();
      if (wr_ok) mq.push_back(d);
      if (w && !wr_ok) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (r && !rd_ok) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
    end
    n = mq.size();
    exp_flags = {n == DEPTH, n == 0, n >= DEPTH/2, n < DEPTH/2,
                 n >= int'(af_thresh), n <= int'(ae_thresh), m_ovf, m_udf};
    #1;
    check("reg_count", 32'(r_count), 32'(n));
    check("reg_flags", 32'({r_full, r_empty, r_hf, r_he, r_af, r_ae, r_ovf, r_udf}), 32'(exp_flags));
    check("reg_dout", 32'(r_dout), 32'(m_dout));
    check("fwft_count", 32'(f_count), 32'(n));
    check("fwft_flags", 32'({f_full, f_empty, f_hf, f_he, f_af, f_ae, f_ovf, f_udf}), 32'(exp_flags));
    if (n > 0) check("fwft_dout", 32'(f_dout), 32'(mq[0]));
    else if (s_rst) check("fwft_dout_rst", 32'(f_dout), 32'h0);
    $display("step %0d rst=%0b w=%0b r=%0b clr=%0b din=%02h af=%0d ae=%0d count=%0d dout=%02h fwft=%02h",
             step_no, s_rst, w, r, clr, d, af_thresh, ae_thresh, r_count, r_dout, f_dout);
  endtask

  initial begin
    step(1, 0, 0, 0, 8'h00);
    step(1, 1, 1, 1, 8'hFF);

    // fill, then one write too many
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'(i));
    step(0, 1, 0, 0, 8'h10);
    check("fill_ovf", 32'(r_ovf), 32'h1);

    // drain in order, then one read too many
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    check("drain_last", 32'(r_dout), 32'h0F);
    step(0, 0, 0, 1, 8'h00);

    // simultaneous at empty, then at full
    step(0, 1, 1, 0, 8'h55);
    check("sim_empty_udf", 32'(r_udf), 32'h1);
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 8'($urandom));
    step(0, 1, 1, 0, 8'h66);
    check("sim_full_cnt", 32'(r_count), 32'd15);
    step(0, 1, 0, 1, 8'h77);
    step(0, 1, 0, 1, 8'h88);
    check("clr_vs_new_err", 32'(r_ovf), 32'h1);

    // hold occupancy at 5 through several pointer wraps
    for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 40; i++) step(0, 1, 1, 0, 8'($urandom));
    check("wrap_cnt", 32'(r_count), 32'd5);

    // random traffic with moving thresholds and occasional reset
    for (int i = 0; i < 300; i++) begin
      if (i % 32 == 0) begin
        af_thresh = 5'($urandom_range(0, 16));
        ae_thresh = 5'($urandom_range(0, 16));
      end
      step(($urandom_range(0, 63) == 0), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), 8'($urandom));
    end

    // reset mid-operation with a write pending
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 8'(8'h30 + i));
    step(0, 1, 1, 0, 8'h99);
    step(1, 1, 0, 0, 8'hEE);
    check("rst_cnt", 32'(r_count), 32'd0);
    step(0, 0, 0, 0, 8'h00);
    check("rst_discard_cnt", 32'(r_count), 32'd0);

    // first-word-fall-through of a single word
    step(0, 1, 0, 0, 8'hA5);
    step(0, 0, 0, 0, 8'h00);
    check("fwft_a5", 32'(f_dout), 32'hA5);
    step(0, 0, 1, 0, 8'h00);
    check("fwft_drain_empty", 32'(f_empty), 32'h1);
    check("reg_a5", 32'(r_dout), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_thresh.md
SYNC_FIFO_THRESH -- requirements
Module: sync_fifo_thresh

Interface
REQ-001 SHALL have parameter DEPTH, default 256, entry count; a power of two and >= 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per entry.
REQ-003 SHALL have parameter PTR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port w_en, input, 1, write request.
REQ-009 SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-010 SHALL have port r_en, input, 1, read request.
REQ-011 SHALL have port data_out, output, DATA_WIDTH, read data.
REQ-012 SHALL have port af_thresh, input, PTR_WIDTH+1, almost-full level.
REQ-013 SHALL have port ae_thresh, input, PTR_WIDTH+1, almost-empty level.
REQ-014 SHALL have outputs full, empty, half_full, half_empty, almost_full and almost_empty, each 1 bit, status flags.
REQ-015 SHALL have port count, output, PTR_WIDTH+1, current occupancy, 0..DEPTH.
REQ-016 SHALL have outputs overflow and underflow, each 1 bit, sticky error flags.
REQ-017 SHALL have port clr_err, input, 1, clears the sticky error flags.

Function
REQ-018 A write SHALL be accepted iff w_en && !full; data_in goes to mem[waddr] and waddr increments modulo DEPTH.
REQ-019 A read SHALL be accepted iff r_en && !empty; raddr increments modulo DEPTH.
REQ-020 count SHALL update on the same edge: +1 write only, -1 read only, unchanged for both or neither.
REQ-021 When full with w_en && r_en, the read SHALL be accepted and the write rejected.
REQ-022 When empty with w_en && r_en, the write SHALL be accepted and the read rejected.
REQ-023 Flags SHALL be registered and consistent with count on every cycle: full = (count==DEPTH), empty = (count==0), half_full = (count>=DEPTH/2), half_empty = (count<DEPTH/2).
REQ-024 almost_full SHALL equal (count>=af_thresh) and almost_empty SHALL equal (count<=ae_thresh), both evaluated on next-count and registered.
REQ-025 Changes to af_thresh and ae_thresh SHALL take effect on the next edge.
REQ-026 With FWFT=0, data_out SHALL present the read word one cycle after the accepting edge and hold until the next accepted read.
REQ-027 With FWFT=1, data_out SHALL always show mem[raddr] while !empty, with the first written word visible the cycle after its write; data_out is don't-care while empty.
REQ-028 A rejected write SHALL set overflow; a rejected read SHALL set underflow; both are sticky.
REQ-029 clr_err SHALL clear both sticky flags next edge; a same-cycle new error SHALL win over clr_err.
REQ-030 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no data loss or flag glitch.

Reset
REQ-031 On rst at an edge: waddr=0, raddr=0, count=0, empty=1, full=0, half_full=0, half_empty=1, almost_full=(af_thresh==0), almost_empty=1, overflow=0, underflow=0, data_out=0.
REQ-032 rst SHALL override w_en, r_en and clr_err in the same cycle; reset mid-operation discards all stored data. Memory contents need not be cleared.

Structure
REQ-033 Package sync_fifo_pkg SHALL hold the default DEPTH and DATA_WIDTH constants and the read-mode enum (MODE_REG, MODE_FWFT).
REQ-034 Storage SHALL be a sub-module fifo_ram (simple dual-port: one write port, one read port, same clk); control, count and flags live in sync_fifo_thresh.

Verification
REQ-035 Bench SHALL use DEPTH=16, DATA_WIDTH=8, af_thresh=12, ae_thresh=3 unless stated.
REQ-036 Fill: 16 writes 0x00..0x0F -> count 16, full=1; almost_full asserts after the 12th write and half_full after the 8th; a 17th write sets overflow with count unchanged.
REQ-037 Drain (FWFT=0): 16 reads -> data_out 0x00..0x0F each one cycle after the accepting edge; empty=1 after the last read; an extra read sets underflow.
REQ-038 Simultaneous: at count=16, w_en+r_en -> count 15 and overflow=1; at count=0, w_en+r_en -> count 1 and underflow=1.
REQ-039 Wrap: 40 interleaved write/read pairs at count 5 -> count stays 5; data order preserved across three pointer wraps; no flag toggles.
REQ-040 FWFT=1: single write 0xA5 into empty -> data_out=0xA5 the next cycle with no r_en; r_en then drains it -> empty=1.
REQ-041 rst asserted at count=9 with w_en=1 -> next cycle count=0, empty=1, sticky flags 0, and the write in the reset cycle is discarded.
